// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD scheduler slice.
package gcd_pkg;

    localparam int unsigned GCD_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } gcd_state_t;

endpackage

// File: rtl/gcd_core.sv
// Subtractive GCD engine: loads on ini, then subtracts the smaller register
// from the larger every cycle until both are equal (fin). The datapath has no
// reset because its controller always loads it before reading it.
module gcd_core
    import gcd_pkg::*;
#(
    parameter int unsigned W = GCD_W
) (
    input  logic         clk,
    input  logic         ini,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] o,
    output logic         fin
);

    logic [W-1:0] a;
    logic [W-1:0] b;

    // Load operands or take one subtraction step.
    always_ff @(posedge clk) begin
        if (ini) begin
            a <= x;
            b <= y;
        end else if (a > b) begin
            a <= a - b;
        end else if (b > a) begin
            b <= b - a;
        end
    end

    assign o   = a;
    assign fin = (a == b);

endmodule

// File: rtl/gcd_scheduler.sv
// Round-robin scheduler sharing one gcd_core among N_REQ requesters.
// Optional iteration timeout: define GCD_TIMEOUT_EN.
module gcd_scheduler
    import gcd_pkg::*;
#(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned W          = GCD_W,
    parameter int unsigned MAX_CYCLES = 65535
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [N_REQ-1:0]                req_valid,
    output logic [N_REQ-1:0]                req_ready,
    input  logic [N_REQ-1:0][W-1:0]         req_x,
    input  logic [N_REQ-1:0][W-1:0]         req_y,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [$clog2(N_REQ)-1:0]        rsp_id,
    output logic [W-1:0]                    rsp_gcd,
    output logic                            rsp_err
);

    localparam int unsigned IW = $clog2(N_REQ);

    gcd_state_t   state;
    gcd_state_t   state_next;
    logic [IW-1:0] ptr;
    logic [IW-1:0] grant_idx;
    logic          found;
    logic          accept;
    logic          zero_in;
    logic [W-1:0]  grant_x;
    logic [W-1:0]  grant_y;
    logic [W-1:0]  op_x;
    logic [W-1:0]  op_y;
    logic          core_ini;
    logic [W-1:0]  core_o;
    logic          core_fin;
    logic          timeout;

    gcd_core #(.W(W)) u_core (
        .clk (clk),
        .ini (core_ini),
        .x   (op_x),
        .y   (op_y),
        .o   (core_o),
        .fin (core_fin)
    );

    // Round-robin search starting one past the last winner.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            logic [IW-1:0] cand;
            cand = IW'((32'(ptr) + i) % N_REQ);
            if (!found && req_valid[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign grant_x = req_x[grant_idx];
    assign grant_y = req_y[grant_idx];
    assign zero_in = (grant_x == '0) || (grant_y == '0);
    assign accept  = (state == IDLE) && found;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; zero operands skip the engine entirely.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (found) state_next = zero_in ? DONE : LOAD;
            LOAD: state_next = RUN;
            RUN:  if (core_fin || timeout) state_next = DONE;
            DONE: if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Grant and engine-load decode.
    always_comb begin
        req_ready = '0;
        core_ini  = 1'b0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
        if (state == LOAD) begin
            core_ini = 1'b1;
        end
    end

    // Capture registers and registered response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= IW'(N_REQ - 1);
            op_x      <= '0;
            op_y      <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_gcd   <= '0;
        end else begin
            rsp_valid <= (state_next == DONE);
            if (accept) begin
                ptr    <= grant_idx;
                rsp_id <= grant_idx;
                op_x   <= grant_x;
                op_y   <= grant_y;
                if (zero_in) begin
                    rsp_gcd <= grant_x | grant_y;
                end
            end else if (state == RUN) begin
                if (core_fin) begin
                    rsp_gcd <= core_o;
                end else if (timeout) begin
                    rsp_gcd <= '0;
                end
            end
        end
    end

`ifdef GCD_TIMEOUT_EN
    localparam int unsigned CW = $clog2(MAX_CYCLES + 1);

    logic [CW-1:0] run_cnt;

    // fin on the limit cycle takes priority over the timeout.
    assign timeout = (state == RUN) && !core_fin && (run_cnt == CW'(MAX_CYCLES - 1));

    // Iteration counter: cleared in LOAD, counts RUN cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt <= '0;
        end else if (state == LOAD) begin
            run_cnt <= '0;
        end else if (state == RUN) begin
            run_cnt <= run_cnt + CW'(1);
        end
    end

    // Error flag for aborted results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err <= 1'b0;
        end else if (accept) begin
            rsp_err <= 1'b0;
        end else if (state == RUN) begin
            if (core_fin) begin
                rsp_err <= 1'b0;
            end else if (timeout) begin
                rsp_err <= 1'b1;
            end
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg = ^32'(MAX_CYCLES);
    assign timeout    = 1'b0;
    assign rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_scheduler.sv
// Self-checking bench for gcd_scheduler: arithmetic reference model plus
// directed vectors with literal expectations. Honours GCD_TIMEOUT_EN.
module tb_gcd_scheduler;

    localparam int N    = 4;
    localparam int W    = 16;
    localparam int MAXC = 100;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [N-1:0]         req_valid = '0;
    logic [N-1:0]         req_ready;
    logic [N-1:0][W-1:0]  req_x = '0;
    logic [N-1:0][W-1:0]  req_y = '0;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b1;
    logic [1:0]           rsp_id;
    logic [W-1:0]         rsp_gcd;
    logic                 rsp_err;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int ini_cnt = 0;

    gcd_scheduler #(.N_REQ(N), .W(W), .MAX_CYCLES(MAXC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_gcd   (rsp_gcd),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) if (dut.core_ini) ini_cnt++;

    function automatic void chk(string nm, longint act, longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endfunction

    // Round-robin winner from the rules: first valid index after p.
    function automatic int pick(logic [N-1:0] v, int p);
        for (int i = 1; i <= N; i++) begin
            int c;
            c = (p + i) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // Result, latency and error flag for one request.
    function automatic void model(input int x, input int y,
                                  output int g, output int lat, output int err);
        longint a, b, k, q;
        err = 0;
        if (x == 0 || y == 0) begin
            g = x | y;
            lat = 1;
            return;
        end
        a = x; b = y; k = 0;
        while (a != b) begin
            if (a > b) begin q = (a - 1) / b; a -= q * b; end
            else       begin q = (b - 1) / a; b -= q * a; end
            k += q;
        end
        g = int'(a);
        lat = int'(k) + 3;
`ifdef GCD_TIMEOUT_EN
        if (k >= MAXC) begin g = 0; err = 1; lat = MAXC + 2; end
`endif
    endfunction

    // Reference model state.
    bit         m_busy = 0;
    int         m_ptr  = N - 1;
    int         m_due, m_id, m_gcd, m_err, m_lat, m_w;
    logic [N-1:0] m_er;

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy = 0;
            m_ptr  = N - 1;
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_rsp_gcd", rsp_gcd, 0);
            chk("rst_rsp_err", rsp_err, 0);
        end else begin
            m_w  = pick(req_valid, m_ptr);
            m_er = '0;
            if (!m_busy && m_w >= 0) m_er[m_w] = 1'b1;
            chk("req_ready", req_ready, m_er);
            if (m_busy) begin
                if (cyc < m_due) begin
                    chk("rsp_valid_early", rsp_valid, 0);
                end else begin
                    chk("rsp_valid", rsp_valid, 1);
                    chk("rsp_id", rsp_id, m_id);
                    chk("rsp_gcd", rsp_gcd, m_gcd);
                    chk("rsp_err", rsp_err, m_err);
                    if (rsp_ready) m_busy = 0;
                end
            end else begin
                chk("rsp_valid_idle", rsp_valid, 0);
                if (m_w >= 0) begin
                    m_busy = 1;
                    m_id   = m_w;
                    m_ptr  = m_w;
                    model(int'(req_x[m_w]), int'(req_y[m_w]), m_gcd, m_lat, m_err);
                    m_due  = cyc + m_lat;
                end
            end
        end
    end

    task automatic do_req(int id, int x, int y, int eg, int el, int ee);
        int t0, t1;
        req_x[id] = W'(x);
        req_y[id] = W'(y);
        req_valid[id] = 1'b1;
        t0 = -1;
        for (int i = 0; i < 200 && t0 < 0; i++) begin
            @(negedge clk);
            if (req_ready[id]) t0 = cyc;
        end
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        chk("accept_seen", t0 >= 0, 1);
        if (t0 < 0) return;
        t1 = -1;
        for (int i = 0; i < 70000 && t1 < 0; i++) begin
            @(negedge clk);
            if (rsp_valid) t1 = cyc;
        end
        chk("lit_latency", t1 - t0, el);
        chk("lit_gcd", rsp_gcd, eg);
        chk("lit_id", rsp_id, id);
        chk("lit_err", rsp_err, ee);
        @(posedge clk); #1;
    endtask

    task automatic wait_grant(output int g);
        g = -1;
        for (int i = 0; i < 200 && g < 0; i++) begin
            @(negedge clk);
            for (int j = 0; j < N; j++) if (req_ready[j]) g = j;
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_rsp();
        int ok;
        ok = 0;
        for (int i = 0; i < 200 && ok == 0; i++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) ok = 1;
        end
        chk("rsp_drained", ok, 1);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        chk("lit_rst_valid", rsp_valid, 0);
        chk("lit_rst_gcd", rsp_gcd, 0);
        chk("lit_rst_id", rsp_id, 0);
        chk("lit_rst_ready", req_ready, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int g0, g1, g2, g3, ic;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        do_req(0, 12, 18, 6, 5, 0);

        ic = ini_cnt;
        do_req(1, 0, 7, 7, 1, 0);
        do_req(2, 0, 0, 0, 1, 0);
        chk("no_ini_on_zero", ini_cnt - ic, 0);

        do_req(3, 9, 9, 9, 3, 0);

        // Backpressure with a competing requester waiting.
        rsp_ready = 1'b0;
        req_x[2] = 16'd35; req_y[2] = 16'd21; req_valid[2] = 1'b1;
        wait_grant(g0);
        req_valid[2] = 1'b0;
        chk("bp_grant", g0, 2);
        g1 = -1;
        for (int i = 0; i < 100 && g1 < 0; i++) begin
            @(negedge clk);
            if (rsp_valid) g1 = cyc;
        end
        @(posedge clk); #1;
        req_x[0] = 16'd4; req_y[0] = 16'd4; req_valid[0] = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("bp_valid", rsp_valid, 1);
            chk("bp_gcd", rsp_gcd, 7);
            chk("bp_id", rsp_id, 2);
            chk("bp_ready", req_ready, 0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_grant(g0);
        req_valid[0] = 1'b0;
        chk("bp_next_grant", g0, 0);
        wait_rsp();

        // Three requesters valid from reset.
        do_reset();
        req_x[0] = 16'd8; req_y[0] = 16'd12;
        req_x[1] = 16'd5; req_y[1] = 16'd10;
        req_x[2] = 16'd7; req_y[2] = 16'd7;
        req_valid = 4'b0111;
        wait_grant(g0); wait_grant(g1); wait_grant(g2); wait_grant(g3);
        req_valid = '0;
        chk("rr_order0", g0, 0);
        chk("rr_order1", g1, 1);
        chk("rr_order2", g2, 2);
        chk("rr_order3", g3, 0);
        wait_rsp();

        // req1 only arrives after req0 and req2 were served.
        do_reset();
        req_valid = 4'b0101;
        wait_grant(g0);
        wait_grant(g1);
        req_valid = 4'b0010;
        wait_grant(g2);
        req_valid = '0;
        chk("late_order0", g0, 0);
        chk("late_order1", g1, 2);
        chk("late_order2", g2, 1);
        wait_rsp();

        // Reset while the engine is iterating.
        req_x[1] = 16'd1; req_y[1] = 16'd1000; req_valid[1] = 1'b1;
        wait_grant(g0);
        req_valid[1] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_run_no_rsp", rsp_valid, 0);
        do_reset();
        do_req(0, 9, 6, 3, 5, 0);

`ifdef GCD_TIMEOUT_EN
        do_req(0, 1, 65535, 0, MAXC + 2, 1);
`else
        do_req(0, 1, 65535, 1, 65537, 0);
`endif

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/gcd_scheduler.md
# gcd_scheduler

Round-robin scheduler that shares one subtractive 16-bit GCD engine between `N_REQ` requesters. It arbitrates incoming operand pairs, sequences the engine through load, iterate and done phases, and returns each result with the ID of the requester that submitted it. Operands equal to zero bypass the engine, which would otherwise never terminate on them. It sits between the requester ports and the GCD datapath as that datapath's only controller.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `W`, 16: operand and result width.
- `MAX_CYCLES`, 65535: iteration limit, used only under `GCD_TIMEOUT_EN`.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in N_REQ: per-requester operand valid.
- `req_ready` out N_REQ: per-requester accept; one-hot or zero.
- `req_x` in N_REQ×W: per-requester operand x.
- `req_y` in N_REQ×W: per-requester operand y.
- `rsp_valid` out 1: result valid.
- `rsp_ready` in 1: result consumer ready.
- `rsp_id` out $clog2(N_REQ): index of the requester that owns the result.
- `rsp_gcd` out W: GCD result.
- `rsp_err` out 1: result aborted by timeout; tied to 0 without `GCD_TIMEOUT_EN`.

## Operation
- FSM states are IDLE, LOAD, RUN and DONE.
- **IDLE**
  - Round-robin arbitration over `req_valid`, with search starting at `ptr+1` (mod N_REQ).
  - `req_ready[g]=1` is combinational and applies only to the winner `g`.
  - On handshake: capture x, y and `g` into registers, then set `ptr<=g`.
- **Zero bypass**
  - If the captured x==0 or y==0, go directly to DONE with result = x|y.
  - The result is therefore 0 when both operands are 0.
  - Otherwise go to LOAD.
- **LOAD**: drive engine `ini=1` for exactly one cycle. Engine registers a←x, b←y. Go to RUN.
- **RUN**
  - Engine `ini=0`. Each cycle the engine subtracts the smaller register from the larger while a≠b.
  - When engine `fin=1`: latch `rsp_gcd<=a`, `rsp_err<=0`, go to DONE.
- **DONE**
  - `rsp_valid=1`, with `rsp_id`, `rsp_gcd` and `rsp_err` held stable.
  - On `rsp_valid&&rsp_ready`, go to IDLE.
  - No new request is accepted while outside IDLE: `req_ready=0`.
- Arithmetic is unsigned W-bit and never underflows, because the engine only subtracts the smaller operand from the larger.

## Timing
- **Reset values**: state=IDLE, `ptr=N_REQ-1` (requester 0 has first priority), `req_ready=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_gcd=0`, `rsp_err=0`, iteration counter=0.
- **Latency, nonzero operands**: with k = number of subtraction steps, `rsp_valid` rises k+3 cycles after the accept cycle. Example: (12,18) takes k=2, so latency is 5.
- **Latency, equal nonzero operands**: k=0, so latency is 3.
- **Latency, zero bypass**: `rsp_valid` rises 1 cycle after accept.
- **Throughput**: one request is in flight at a time. The earliest next accept is the cycle after the response handshake.
- **Backpressure**: `rsp_ready=0` holds DONE indefinitely with outputs stable.
- **Reset mid-operation**: any state returns to IDLE immediately. The in-flight request is dropped and no response is issued.
- **Requester behaviour**: a requester may drop `req_valid` before it is granted, and nothing is captured in that case.

## Configuration
- **`GCD_TIMEOUT_EN` defined**
  - A counter clears in LOAD and increments each RUN cycle.
  - If it reaches `MAX_CYCLES` with `fin=0`: go to DONE with `rsp_gcd=0` and `rsp_err=1`.
  - If `fin` and the limit occur in the same cycle, `fin` wins.
- **`GCD_TIMEOUT_EN` undefined**
  - No counter is built and `rsp_err` is constant 0.
  - RUN always terminates, because zero operands bypass the engine.

## Structure
- Package `gcd_pkg` holds:
  - the state enum `gcd_state_t` (IDLE, LOAD, RUN, DONE);
  - the default width constant `GCD_W=16`.
- Sub-module `gcd_core` is the subtractive engine. Its ports are `clk`, `ini`, `x`, `y`, `o` and `fin`, and it is parameterized by W.
- `gcd_scheduler` holds the arbiter, FSM, capture registers and timeout counter.

## Test plan
- **Single request**: req0 submits (12,18), with `rsp_ready=1` → `rsp_valid` 5 cycles after accept, `rsp_gcd=6`, `rsp_id=0`, `rsp_err=0`.
- **Zero operands**:
  - (0,7) → `rsp_gcd=7` one cycle after accept.
  - (0,0) → `rsp_gcd=0`.
  - Neither case ever asserts `ini`.
- **Contention**:
  - req0, req1 and req2 are continuously valid from reset → grant order is 0,1,2,0.
  - With req1 only re-asserting later → order is 0,2,1.
- **Backpressure**: (35,21) with `rsp_ready` low for 10 cycles → `rsp_valid`, `rsp_gcd=7` and `rsp_id` are held stable; `req_ready` stays 0 throughout.
- **Reset mid-RUN**: pulse `rst_n` low during RUN of (1,1000) → all outputs at reset values; the next request (9,6) → 3.
- **Timeout** (`GCD_TIMEOUT_EN`, `MAX_CYCLES=100`): (1,65535) → `rsp_err=1` and `rsp_gcd=0` after 100 RUN cycles. Without the macro, the same request returns 1.
